// File: rtl/ram_upload.sv
// ram_upload: fetches a block of SDRAM bytes into a 4-entry FIFO and serves them MSB-first as an SPI slave.
// Optional feature macro UPLOAD_CRC_EN appends a CRC-16-CCITT trailer (high byte, then low byte).
module ram_upload (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [24:0] base_addr,
    input  logic [16:0] length,
    input  logic        mem_sync,
    output logic [24:0] mem_adr,
    output logic        mem_rd,
    input  logic [7:0]  mem_di,
    input  logic        SPI_SCK,
    input  logic        SPI_SS2,
    output logic        spi_do,
    output logic        spi_do_oe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam int unsigned LEN_W  = 17;
    localparam int unsigned CNT_W  = 18;
    localparam int unsigned FIFO_D = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned FCNT_W = 3;

`ifdef UPLOAD_CRC_EN
    localparam logic [CNT_W-1:0] TRAILER = CNT_W'(2);
`else
    localparam logic [CNT_W-1:0] TRAILER = CNT_W'(0);
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
    state_t state, state_next;

    logic [LEN_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  send_cnt;
    logic [7:0]        fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_next;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_cnt;
    logic              final_sent;
    logic              sck_meta, sck_s, sck_d, ss2_meta, ss2_d;
    logic              ss2_s, ss2_fall, ss2_rise, sck_rise, sck_fall, byte_end, load;
    logic              start_ok, take_rd, push, pop;
    logic              take_head, consume, starve, in_trailer;
    logic [7:0]        next_byte, trailer_byte;
    logic              mem_rd_next, busy_next, done_next;

    // Second SS2 synchroniser stage is stored inverted so it doubles as the output enable.
    assign ss2_s    = ~spi_do_oe;
    assign ss2_fall = ss2_d & ~ss2_s;
    assign ss2_rise = ~ss2_d & ss2_s;
    assign sck_rise = ~ss2_s & sck_s & ~sck_d;
    assign sck_fall = ~ss2_s & ~sck_s & sck_d;
    assign byte_end = sck_rise && (bit_cnt == 3'd7);
    assign load     = ss2_fall | byte_end;
    assign spi_do   = shift_reg[7];

    assign start_ok = start && (state == S_IDLE) && (length != '0);
    assign take_rd  = (state == S_REQ) && mem_rd && mem_sync;
    assign push     = (state == S_WAIT) && mem_sync;
    assign pop      = load & take_head;

`ifdef UPLOAD_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign in_trailer   = (send_cnt <= CNT_W'(2));
    assign trailer_byte = (send_cnt == CNT_W'(2)) ? crc[15:8] : crc[7:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            crc <= 16'hFFFF;
        end else if (start_ok) begin
            crc <= 16'hFFFF;
        end else if (load && consume && !in_trailer) begin
            crc <= crc_step(crc, next_byte);
        end
    end
`else
    assign in_trailer   = 1'b0;
    assign trailer_byte = 8'hFF;
`endif

    // Byte to present at the next load: payload, trailer, underrun filler or idle filler.
    always_comb begin
        next_byte = 8'hFF;
        take_head = 1'b0;
        consume   = 1'b0;
        starve    = 1'b0;
        if (send_cnt != '0) begin
            consume = 1'b1;
            if (in_trailer) begin
                next_byte = trailer_byte;
            end else if (fifo_cnt != '0) begin
                next_byte = fifo_mem[rd_ptr];
                take_head = 1'b1;
            end else begin
                starve = 1'b1;
            end
        end
    end

    always_comb begin
        if (start_ok) begin
            fifo_cnt_next = '0;
        end else begin
            fifo_cnt_next = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_REQ;
            S_REQ:   if (take_rd) state_next = S_WAIT;
            S_WAIT:  if (mem_sync) state_next = (fetch_cnt == LEN_W'(1)) ? S_DRAIN : S_REQ;
            S_DRAIN: begin
                if ((send_cnt == '0) && final_sent) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        busy_next   = (state_next != S_IDLE);
        mem_rd_next = (state_next == S_REQ) && (fifo_cnt_next != FCNT_W'(FIFO_D));
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_di;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_meta   <= 1'b0;
            sck_s      <= 1'b0;
            sck_d      <= 1'b0;
            ss2_meta   <= 1'b1;
            spi_do_oe  <= 1'b0;
            ss2_d      <= 1'b1;
            mem_rd     <= 1'b0;
            mem_adr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            fetch_cnt  <= '0;
            send_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            shift_reg  <= 8'hFF;
            bit_cnt    <= '0;
            final_sent <= 1'b0;
        end else begin
            sck_meta  <= SPI_SCK;
            sck_s     <= sck_meta;
            sck_d     <= sck_s;
            ss2_meta  <= SPI_SS2;
            spi_do_oe <= ~ss2_meta;
            ss2_d     <= ss2_s;
            mem_rd    <= mem_rd_next;
            busy      <= busy_next;
            done      <= done_next;
            fifo_cnt  <= fifo_cnt_next;

            if (ss2_fall || ss2_rise) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (load) begin
                shift_reg <= next_byte;
            end else if (sck_fall) begin
                shift_reg <= {shift_reg[6:0], 1'b1};
            end

            if (push) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                fetch_cnt <= fetch_cnt - LEN_W'(1);
            end
            if (take_rd) mem_adr <= mem_adr + 25'd1;
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (load && consume) send_cnt <= send_cnt - CNT_W'(1);
            if (load && starve) underrun <= 1'b1;
            // A full byte clocked out after the last counted load means the payload is delivered.
            if (byte_end && (send_cnt == '0)) final_sent <= 1'b1;

            if (start_ok) begin
                mem_adr    <= base_addr;
                fetch_cnt  <= length;
                send_cnt   <= CNT_W'(length) + TRAILER;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                underrun   <= 1'b0;
                final_sent <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram_upload.sv
// Scoreboard bench for ram_upload: expected SPI bytes and read addresses are queued at issue time.
module tb_ram_upload;
`ifdef UPLOAD_CRC_EN
    localparam int TR = 2;
`else
    localparam int TR = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset, start, mem_sync, mem_rd, SPI_SCK, SPI_SS2;
    logic        spi_do, spi_do_oe, busy, done, underrun;
    logic [24:0] base_addr, mem_adr;
    logic [16:0] length;
    logic [7:0]  mem_di = 8'h00;

    logic [7:0]  mem_arr [256];
    logic [7:0]  exp_q [$];
    logic [24:0] adr_q [$];
    int          checks = 0, failures = 0;
    int          done_cnt = 0, rd_cnt = 0;
    bit          sync_en = 1'b0;
    logic [7:0]  rx_sh = 8'h00;
    int          rx_bits = 0;

    always #5 clk_sys = ~clk_sys;

    ram_upload dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .mem_sync(mem_sync), .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_di(mem_di),
        .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .spi_do(spi_do), .spi_do_oe(spi_do_oe),
        .busy(busy), .done(done), .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef UPLOAD_CRC_EN
    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    // Memory slot strobes, one cycle wide, 4..9 cycles apart.
    initial begin
        mem_sync = 1'b0;
        forever begin
            repeat ($urandom_range(3, 8)) @(posedge clk_sys);
            #1 mem_sync = sync_en;
            @(posedge clk_sys);
            #1 mem_sync = 1'b0;
        end
    end

    // Memory model and read-address / done monitor.
    always @(negedge clk_sys) begin
        if (!reset && mem_sync && mem_rd) begin
            rd_cnt++;
            if (adr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_adr: unexpected read at 0x%0h", mem_adr);
            end else begin
                check("mem_adr", 32'(mem_adr), 32'(adr_q.pop_front()));
            end
            mem_di = mem_arr[mem_adr[7:0]];
        end
        if (done) done_cnt++;
    end

    // SPI receiver: the master samples on each SCK fall while selected.
    always @(negedge SPI_SCK or posedge SPI_SS2) begin
        if (SPI_SS2) begin
            rx_bits = 0;
        end else begin
            rx_sh = {rx_sh[6:0], spi_do};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spi_byte: unexpected byte 0x%0h", rx_sh);
                end else begin
                    check("spi_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic spi_read(input int nbytes);
        SPI_SS2 = 1'b0;
        cycles(4);
        check("spi_do_oe_sel", 32'(spi_do_oe), 32'd1);
        for (int i = 0; i < nbytes * 8; i++) begin
            SPI_SCK = 1'b0;
            cycles(4);
            SPI_SCK = 1'b1;
            cycles(4);
        end
        SPI_SS2 = 1'b1;
        cycles(4);
    endtask

    task automatic do_start(input logic [24:0] a, input logic [16:0] l);
        @(posedge clk_sys);
        #1;
        base_addr = a;
        length    = l;
        start     = 1'b1;
        cycles(1);
        start     = 1'b0;
    endtask

    // Expected SPI stream: n_under filler bytes, remaining payload, optional CRC, then idle filler.
    task automatic expect_upload(input logic [24:0] base, input int len, input int n_under, input int nread);
        logic [7:0]  sent [$];
        logic [15:0] crc;
        for (int i = 0; i < len; i++) adr_q.push_back(base + 25'(i));
        for (int i = 0; i < n_under; i++) sent.push_back(8'hFF);
        for (int i = 0; i < len - n_under; i++) sent.push_back(mem_arr[8'(base + 25'(i))]);
        crc = 16'hFFFF;
`ifdef UPLOAD_CRC_EN
        foreach (sent[i]) crc = crc16(crc, sent[i]);
        sent.push_back(crc[15:8]);
        sent.push_back(crc[7:0]);
`endif
        while (sent.size() < nread) sent.push_back(8'hFF);
        foreach (sent[i]) exp_q.push_back(sent[i]);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            cycles(1);
            n++;
        end
        check("done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_upload(input logic [24:0] base, input int len, input int extra);
        int d0 = done_cnt;
        int r0 = rd_cnt;
        expect_upload(base, len, 0, len + TR + extra);
        do_start(base, 17'(len));
        cycles(40);
        spi_read(len + TR + extra);
        wait_done(d0 + 1);
        check("reads", 32'(rd_cnt - r0), 32'(len));
        check("underrun_clean", 32'(underrun), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, r0, n;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        SPI_SCK = 1'b1; SPI_SS2 = 1'b1;
        cycles(4);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_oe", 32'(spi_do_oe), 32'd0);
        check("rst_spi_do", 32'(spi_do), 32'd1);
        reset = 1'b0;
        sync_en = 1'b1;
        cycles(4);

        // Directed upload of four known bytes plus one trailing read.
        mem_arr[0] = 8'h11; mem_arr[1] = 8'h22; mem_arr[2] = 8'h33; mem_arr[3] = 8'h44;
        run_upload(25'h0280000, 4, 1);

        // SPI clocks before any fetch completes: first byte is filler.
        d0 = done_cnt;
        sync_en = 1'b0;
        expect_upload(25'h0000040, 3, 1, 3 + TR);
        do_start(25'h0000040, 17'd3);
        fork
            spi_read(3 + TR);
            begin
                cycles(12);
                sync_en = 1'b1;
            end
        join
        wait_done(d0 + 1);
        check("underrun_set", 32'(underrun), 32'd1);

        // Zero-length start is a no-op.
        d0 = done_cnt;
        r0 = rd_cnt;
        do_start(25'h0001000, 17'd0);
        for (int i = 0; i < 5; i++) begin
            cycles(4);
            check("len0_busy", 32'(busy), 32'd0);
        end
        check("len0_reads", 32'(rd_cnt - r0), 32'd0);
        check("len0_done", 32'(done_cnt - d0), 32'd0);

        // A start while busy is ignored.
        d0 = done_cnt;
        r0 = rd_cnt;
        expect_upload(25'h0100020, 8, 0, 8 + TR);
        do_start(25'h0100020, 17'd8);
        cycles(8);
        do_start(25'h0155500, 17'd5);
        cycles(30);
        spi_read(8 + TR);
        wait_done(d0 + 1);
        check("busy_start_reads", 32'(rd_cnt - r0), 32'd8);

        // Reset in mid-upload aborts without done; the next upload runs normally.
        d0 = done_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 6; i++) adr_q.push_back(25'h0020000 + 25'(i));
        do_start(25'h0020000, 17'd6);
        n = 0;
        while (rd_cnt - r0 < 2 && n < 300) begin
            cycles(1);
            n++;
        end
        check("reads_before_reset", 32'(rd_cnt - r0), 32'd2);
        cycles(6);
        reset = 1'b1;
        cycles(1);
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        adr_q.delete();
        exp_q.delete();
        cycles(30);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_upload(25'h0030010, 2, 0);

`ifdef UPLOAD_CRC_EN
        // Known CRC of a single zero byte.
        d0 = done_cnt;
        mem_arr[8'h80] = 8'h00;
        adr_q.push_back(25'h0000080);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hF0);
        do_start(25'h0000080, 17'd1);
        cycles(40);
        spi_read(3);
        wait_done(d0 + 1);
`endif

        // Randomised uploads, first one wrapping the 25-bit address.
        for (int t = 0; t < 6; t++) begin
            logic [24:0] b;
            b = (t == 0) ? 25'h1FFFFFE : 25'($urandom);
            run_upload(b, $urandom_range(1, 10), $urandom_range(0, 2));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("adr_q_drained", 32'(adr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_upload.md
RAM_UPLOAD -- requirements
Module: ram_upload

Interface
REQ-001 SHALL have ports: clk_sys  in  1  system clock, 32 MHz; the only clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle upload request.
REQ-004 SHALL have ports: base_addr  in  25  first SDRAM byte address.
REQ-005 SHALL have ports: length  in  17  payload byte count; 0 means no operation.
REQ-006 SHALL have ports: mem_sync  in  1  one-cycle memory slot strobe, spaced at least 4 clk_sys apart.
REQ-007 SHALL have ports: mem_adr  out  25  read address.
REQ-008 SHALL have ports: mem_rd  out  1  read request.
REQ-009 SHALL have ports: mem_di  in  8  read data.
REQ-010 SHALL have ports: SPI_SCK  in  1  io-controller SPI clock, asynchronous.
REQ-011 SHALL have ports: SPI_SS2  in  1  active-low select, asynchronous.
REQ-012 SHALL have ports: spi_do  out  1  serial data.
REQ-013 SHALL have ports: spi_do_oe  out  1  output enable.
REQ-014 SHALL have ports: busy  out  1  upload in progress.
REQ-015 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-016 SHALL have ports: underrun  out  1  sticky error flag.

Function
REQ-017 SHALL sample base_addr and length on start when the FSM is in IDLE; start SHALL be ignored in every other state; start with length=0 SHALL leave the block in IDLE with busy=0.
REQ-018 SHALL implement the fetch FSM IDLE -> REQ -> WAIT -> (REQ | DRAIN) -> IDLE.
REQ-019 In REQ, the block SHALL hold mem_rd=1 and mem_adr=address only while the 4-entry FIFO has a free slot not already reserved by an outstanding read; at the first mem_sync with mem_rd=1, it SHALL go to WAIT and increment the address by 1 (25-bit wrap).
REQ-020 In WAIT, mem_rd SHALL be 0; on the next mem_sync, the block SHALL push mem_di into the FIFO and decrement the fetch count; it SHALL then go to REQ if the count is non-zero, otherwise to DRAIN.
REQ-021 The block SHALL pass SPI_SCK and SPI_SS2 through 2-flop synchronisers and act on their edges detected in clk_sys (maximum SCK of 8 MHz).
REQ-022 spi_do_oe SHALL equal the inverted synchronised SS2; spi_do SHALL equal shift-register bit 7 (MSB first).
REQ-023 On an SS2 falling edge, and on the 8th SCK rising edge of a byte while SS2 stays low, the block SHALL load the shift register with the next output byte.
REQ-024 The block SHALL shift left by 1 on each SCK falling edge, filling with 1.
REQ-025 The output byte SHALL be the FIFO head (popped), which decrements the send count; if the FIFO is empty while send count>0, the output byte SHALL be 0xFF, underrun SHALL be set, and the send count SHALL still decrement; once send count=0, the output byte SHALL be 0xFF.
REQ-026 A bit counter SHALL reset on SS2 rise; a partial byte SHALL be discarded; the loaded byte SHALL stay popped.
REQ-027 In DRAIN, when the send count reaches 0 and the final byte has completed its 8th rising edge, the FSM SHALL go to IDLE, pulse done for 1 cycle, and set busy=0.
REQ-028 busy SHALL be 1 in every non-IDLE state.
REQ-029 underrun SHALL be cleared only by reset or by an accepted start.

Reset
REQ-030 When reset=1, the block SHALL force IDLE, FIFO empty, counts 0, shift register 0xFF, mem_rd=0, mem_adr=0, busy=0, done=0, underrun=0, and spi_do_oe=0 until the synchroniser refills.
REQ-031 Reset during an upload SHALL abort it with no done pulse; a mem_sync arriving after reset SHALL not push into the FIFO.

Configuration
REQ-032 With UPLOAD_CRC_EN defined, the block SHALL emit, after the payload, 2 extra bytes: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first), high byte then low byte, computed over the bytes actually sent (0xFF included on underrun). The send count SHALL be length+2, and done SHALL fire after the second CRC byte.
REQ-033 Without UPLOAD_CRC_EN, the block SHALL not emit CRC bytes, and the send count SHALL equal length.

Verification
REQ-034 base_addr=0x0280000, length=4, memory returns 0x11,0x22,0x33,0x44, SPI reads 5 bytes -> SPI receives 11 22 33 44 FF; mem_adr sequence 0x0280000..0x0280003; one done pulse; underrun=0.
REQ-035 length=3, SPI begins clocking before the first mem_sync -> first byte FF, underrun=1, the remaining 2 bytes are fetched data, then done.
REQ-036 start with length=0 -> busy stays 0, no mem_rd, no done.
REQ-037 Second start asserted 10 cycles into a length=8 upload -> ignored; exactly 8 reads issued; one done.
REQ-038 reset asserted after the 2nd of 6 fetches -> mem_rd=0 next cycle, busy=0, no done; a new start with length=2 completes normally.
REQ-039 With UPLOAD_CRC_EN, length=1, data 0x00 -> SPI receives 00 E1 F0; done after the 3rd byte.
